// File: rtl/riscky_pkg.sv
// Shared definitions for the riscky core: memory geometry and fetch-path types.
package riscky_pkg;

    localparam int ILEN        = 32;
    localparam int IMEM_AW     = 10;
    localparam int IMEM_WORDS  = 1 << IMEM_AW;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} pairs between fetch and decode.
// Flush wins over push and pop; a push into a full buffer is accepted only
// when a pop frees the head slot in the same cycle.
module fetch_buffer
    import riscky_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    fetch_entry_t  r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy tracking; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch controller: owns the fetch PC, drives the combinational
// instruction memory, buffers fetched words and hands them to decode.
module fetch_unit
    import riscky_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              FB_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [ILEN-1:0]    imem_rdata,
    output logic               instr_valid,
    output logic [ILEN-1:0]    instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               halted,
    output logic               misalign_err,
    output logic [31:0]        fetch_count
);

    fetch_state_e              r_state;
    logic [PC_W-1:0]           r_fetch_pc;
    logic                      r_misalign;
    logic [31:0]               r_fetch_count;

    fetch_entry_t              w_entry;
    fetch_entry_t              w_head;
    logic [$clog2(FB_DEPTH):0] w_count;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_accept_pop;

    // A full buffer can still take a new word when decode drains the head
    // in the same cycle, which is what sustains one instruction per cycle.
    assign w_pop        = !w_empty && instr_ready;
    assign w_accept_pop = w_pop && !redirect_valid;
    assign w_push       = (r_state == FS_RUN) && !halt && !redirect_valid
                          && (!w_full || w_pop);

    assign w_entry.pc    = XLEN'(r_fetch_pc);
    assign w_entry.instr = imem_rdata;

    fetch_buffer #(
        .DEPTH (FB_DEPTH)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_accept_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Fetch PC: redirect target (word aligned) wins, otherwise advance on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + PC_W'(INSTR_BYTES);
        end
    end

    // Run/halt state machine; halt is sampled every edge, redirects do not change state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_RUN;
        end else begin
            case (r_state)
                FS_RUN:    if (halt)  r_state <= FS_HALTED;
                FS_HALTED: if (!halt) r_state <= FS_RUN;
                default:              r_state <= FS_RUN;
            endcase
        end
    end

    // One-cycle misalignment pulse following a redirect with nonzero low bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    // Delivered-instruction counter; pops swallowed by a flush are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_accept_pop) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign imem_addr    = r_fetch_pc[IMEM_AW+1:2];
    assign instr_valid  = !w_empty;
    assign instr        = w_empty ? '0 : w_head.instr;
    assign instr_pc     = w_empty ? '0 : PC_W'(w_head.pc);
    assign halted       = (r_state == FS_HALTED) && (w_count == '0);
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a queue-based reference model.
module tb_fetch_unit;
    import riscky_pkg::*;

    localparam int DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [IMEM_AW-1:0] imem_addr;
    logic [ILEN-1:0]    imem_rdata;
    logic               instr_valid;
    logic [ILEN-1:0]    instr;
    logic [31:0]        instr_pc;
    logic               instr_ready;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               halt;
    logic               halted;
    logic               misalign_err;
    logic [31:0]        fetch_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory image: word k holds 0x1000_0000 + k.
    assign imem_rdata = 32'h1000_0000 + {22'd0, imem_addr};

    fetch_unit #(.PC_W(32), .RESET_PC(32'h0), .FB_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_mis;
    logic [31:0] m_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) % IMEM_WORDS);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_halt = 0;
        m_mis  = 0;
        m_cnt  = 0;
    endfunction

    function automatic void model_step();
        bit   pop;
        bit   push;
        ent_t e;
        pop = (mq.size() > 0) && instr_ready;
        if (redirect_valid) begin
            mq.delete();
            m_mis = (redirect_pc[1:0] != 2'b00);
            m_pc  = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            m_mis = 0;
            push  = !m_halt && !halt && ((mq.size() < DEPTH) || pop);
            if (pop) begin
                void'(mq.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (push) begin
                e.pc  = m_pc;
                e.ins = mem_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 4;
            end
        end
        m_halt = halt;
    endfunction

    function automatic bit e_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic [31:0] e_pc();
        return (mq.size() > 0) ? mq[0].pc : 32'h0;
    endfunction

    function automatic logic [31:0] e_ins();
        return (mq.size() > 0) ? mq[0].ins : 32'h0;
    endfunction

    // Advance DUT and model by one edge, leaving time 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; halt = 1'b0;
        model_reset();
        #12;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
        n_vec++; if (imem_addr !== '0) begin n_err++; $display("FAIL reset_addr got %0h want 0", imem_addr); end
        n_vec++; if ({instr, instr_pc, fetch_count} !== '0) begin n_err++; $display("FAIL reset_data got %0h/%0h/%0d want 0", instr, instr_pc, fetch_count); end
        n_vec++; if ({halted, misalign_err} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %0b%0b want 00", halted, misalign_err); end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL pre_edge_valid got %0b want 0", instr_valid); end
    endtask

    task automatic test_stream();
        instr_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0b want 1", k, instr_valid); end
            n_vec++; if (instr_pc !== 32'(4*k)) begin n_err++; $display("FAIL stream_pc[%0d] got %0h want %0h", k, instr_pc, 4*k); end
            n_vec++; if (instr !== 32'h1000_0000 + 32'(k)) begin n_err++; $display("FAIL stream_instr[%0d] got %0h want %0h", k, instr, 32'h1000_0000 + 32'(k)); end
            tick();
        end
        n_vec++; if (fetch_count !== 32'd3) begin n_err++; $display("FAIL stream_count got %0d want 3", fetch_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got pc %0h v %0b want 0/1", c, instr_pc, instr_valid); end
            if (c >= 1) begin
                n_vec++; if (imem_addr !== 10'd2) begin n_err++; $display("FAIL bp_addr[%0d] got %0d want 2", c, imem_addr); end
            end
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_vec++; if (instr_pc !== 32'(4*k) || instr !== e_ins()) begin n_err++; $display("FAIL bp_resume[%0d] got %0h/%0h want %0h/%0h", k, instr_pc, instr, 4*k, e_ins()); end
            tick();
        end
        n_vec++; if (fetch_count !== m_cnt) begin n_err++; $display("FAIL bp_count got %0d want %0d", fetch_count, m_cnt); end
    endtask

    task automatic test_redirect();
        logic [31:0] c0;
        do_reset();
        instr_ready = 1'b0;
        tick(); tick();
        c0 = fetch_count;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush got %0b want 0", instr_valid); end
        tick();
        n_vec++; if (instr_pc !== 32'h40 || instr !== 32'h1000_0010) begin n_err++; $display("FAIL redir_target got %0h/%0h want 40/10000010", instr_pc, instr); end
        instr_ready = 1'b1;
        tick();
        n_vec++; if (fetch_count !== c0 + 1) begin n_err++; $display("FAIL redir_count got %0d want %0d", fetch_count, c0 + 1); end
    endtask

    task automatic test_misalign();
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (misalign_err !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL mis_pulse got err %0b v %0b want 1/0", misalign_err, instr_valid); end
        tick();
        n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_clear got %0b want 0", misalign_err); end
        n_vec++; if (instr_pc !== 32'h20 || instr !== 32'h1000_0008) begin n_err++; $display("FAIL mis_target got %0h/%0h want 20/10000008", instr_pc, instr); end
    endtask

    task automatic test_halt();
        logic [IMEM_AW-1:0] a0;
        bit                 seen;
        do_reset();
        instr_ready = 1'b0;
        tick(); tick();
        halt = 1'b1; instr_ready = 1'b1;
        tick();
        n_vec++; if (halted !== 1'b0 || instr_pc !== 32'h4) begin n_err++; $display("FAIL halt_drain1 got h %0b pc %0h want 0/4", halted, instr_pc); end
        tick();
        n_vec++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL halt_drained got h %0b v %0b want 1/0", halted, instr_valid); end
        n_vec++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL halt_count got %0d want 2", fetch_count); end
        a0 = imem_addr;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (imem_addr !== a0 || halted !== 1'b1) begin n_err++; $display("FAIL halt_stable[%0d] got %0d/%0b want %0d/1", c, imem_addr, halted, a0); end
        end
        halt = 1'b0;
        seen = 0;
        for (int c = 0; c < 4 && !seen; c++) begin
            tick();
            if (instr_valid === 1'b1) seen = 1;
        end
        n_vec++; if (!seen || instr_pc !== 32'h8 || instr !== 32'h1000_0002) begin n_err++; $display("FAIL halt_resume got v %0b pc %0h ins %0h want 1/8/10000002", instr_valid, instr_pc, instr); end
    endtask

    task automatic test_wrap();
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_vec++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'h1000_03FF) begin n_err++; $display("FAIL wrap_top got %0h/%0h want fffffffc/100003ff", instr_pc, instr); end
        tick();
        n_vec++; if (instr_pc !== 32'h0 || instr !== 32'h1000_0000) begin n_err++; $display("FAIL wrap_zero got %0h/%0h want 0/10000000", instr_pc, instr); end
    endtask

    task automatic test_async_reset();
        bit seen;
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick();
        redirect_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 6 && !seen; c++) begin
            tick();
            if (instr_valid === 1'b1 && instr_pc === 32'h30) seen = 1;
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL arst_reach got pc %0h want 30", instr_pc); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if ({instr_valid, instr, instr_pc, fetch_count, halted, misalign_err} !== '0 || imem_addr !== '0) begin n_err++; $display("FAIL arst_zero got v %0b pc %0h cnt %0d addr %0d want all 0", instr_valid, instr_pc, fetch_count, imem_addr); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fetch_count !== 32'd0) begin n_err++; $display("FAIL arst_restart got v %0b pc %0h cnt %0d want 1/0/0", instr_valid, instr_pc, fetch_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = (c % 3 == 0) ? $urandom() : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) halt = ~halt;
            tick();
            n_vec++; if (instr_valid !== e_valid()) begin n_err++; $display("FAIL rnd_valid[%0d] got %0b want %0b", c, instr_valid, e_valid()); end
            n_vec++; if (instr_pc !== e_pc() || instr !== e_ins()) begin n_err++; $display("FAIL rnd_head[%0d] got %0h/%0h want %0h/%0h", c, instr_pc, instr, e_pc(), e_ins()); end
            n_vec++; if (imem_addr !== m_pc[IMEM_AW+1:2]) begin n_err++; $display("FAIL rnd_addr[%0d] got %0h want %0h", c, imem_addr, m_pc[IMEM_AW+1:2]); end
            n_vec++; if (halted !== (m_halt && mq.size() == 0)) begin n_err++; $display("FAIL rnd_halted[%0d] got %0b want %0b", c, halted, (m_halt && mq.size() == 0)); end
            n_vec++; if (misalign_err !== m_mis) begin n_err++; $display("FAIL rnd_mis[%0d] got %0b want %0b", c, misalign_err, m_mis); end
            n_vec++; if (fetch_count !== m_cnt) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, fetch_count, m_cnt); end
        end
        redirect_valid = 1'b0;
        halt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch controller that sequences the single-ported, combinational-read instruction memory.
- Owns the fetch PC and converts it to a word index for the memory.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush), halt (fetch stall) and counts delivered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
- FB_DEPTH, 2, fetch buffer entries; power of two, at least 2.
- PC_W, 32, PC width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  IMEM_AW  word index to the instruction memory; equals fetch_pc[IMEM_AW+1:2].
- imem_rdata  input  ILEN  instruction word; combinational from imem_addr in the same cycle.
- instr_valid  output  1  buffer head is valid.
- instr  output  ILEN  buffer head instruction.
- instr_pc  output  PC_W  byte PC of the buffer head.
- instr_ready  input  1  decode accepts the head; a handshake occurs when instr_valid && instr_ready.
- redirect_valid  input  1  one-cycle request to change the fetch stream.
- redirect_pc  input  PC_W  target byte address.
- halt  input  1  level; while high, no new fetches are issued.
- halted  output  1  high when in HALTED with the buffer empty.
- misalign_err  output  1  registered one-cycle pulse when redirect_pc[1:0] != 0.
- fetch_count  output  32  count of handshakes since reset; wraps at 2^32.

Behaviour:
- Reset (async, rst_n low):
  - fetch_pc = RESET_PC; buffer empty; state RUN.
  - All outputs 0 except imem_addr = RESET_PC[IMEM_AW+1:2].
- Push condition: state RUN && !redirect_valid && (count < FB_DEPTH || pop).
  - On push, {fetch_pc, imem_rdata} is written at the tail and fetch_pc <= fetch_pc + 4.
- Pop = instr_valid && instr_ready; the head advances.
- Push and pop may occur in the same cycle, including when the buffer is full. There is no bypass: the output is always the registered head.
- Latency:
  - The first instruction is valid one cycle after the first rising edge with rst_n high.
  - Sustained throughput is 1 instruction/cycle when instr_ready is held high.
- Stability: while instr_valid && !instr_ready, instr and instr_pc hold.
- Redirect (highest priority, same cycle):
  - Buffer flushed; any pop that cycle is ignored.
  - fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00}; no push.
  - instr_valid = 0 the next cycle; the target instruction is valid the cycle after.
  - If redirect_pc[1:0] != 0, misalign_err pulses the following cycle and the low bits are dropped.
  - A redirect during HALTED updates fetch_pc and flushes, but the state stays HALTED.
- FSM:
  - RUN -> HALTED when halt = 1 (evaluated each edge; no push in a cycle where halt = 1).
  - HALTED -> RUN when halt = 0; fetching resumes from the held fetch_pc.
  - The buffer keeps draining in HALTED.
  - halted = (state == HALTED) && count == 0.
- PC arithmetic:
  - fetch_pc wraps modulo 2^PC_W.
  - The index uses the low IMEM_AW word bits only, so addresses beyond IMEM_WORDS alias. This is intentional; no error is raised.
- fetch_count increments on each pop, and not on flushed entries.
- Reset asserted mid-operation: immediate return to the reset state; in-flight entries are discarded.

Decomposition:
- riscky_pkg (existing) supplies ILEN, IMEM_AW, IMEM_WORDS.
- Add to riscky_pkg:
  - fetch_state_e {FS_RUN, FS_HALTED};
  - typedef fetch_entry_t struct {pc, instr};
  - localparam INSTR_BYTES = 4.
- Sub-module fetch_buffer: generic synchronous FIFO of fetch_entry_t with push/pop/flush, count and full/empty.
  - Flush has priority over push/pop.
  - Async active-low reset.
- fetch_unit instantiates fetch_buffer and holds the PC register, FSM and counter.

Test Plan:
- Bench memory model: word k = 32'h1000_0000 + k. Use RESET_PC = 0.
- Reset and stream: release rst_n, instr_ready = 1 -> instr_valid rises one cycle after the first edge. Successive (instr_pc, instr) = (0x0, 0x1000_0000), (0x4, 0x1000_0001), (0x8, 0x1000_0002), one per cycle. fetch_count = 3 after 3 handshakes.
- Backpressure: instr_ready = 0 for 5 cycles -> buffer fills at 2 entries, instr_pc holds 0x0 and imem_addr freezes at 2. With instr_ready = 1 again, no instruction is lost or duplicated (0x0, 0x4, 0x8 ...).
- Redirect: redirect_valid with redirect_pc = 0x40 while the buffer holds 2 entries -> instr_valid = 0 next cycle. The cycle after, instr_pc = 0x40 and instr = 0x1000_0010. Flushed entries are not counted.
- Misaligned redirect: redirect_pc = 0x22 -> misalign_err pulses for 1 cycle; next instr_pc = 0x20, instr = 0x1000_0008.
- Halt: assert halt with 2 entries buffered and instr_ready = 1 -> 2 handshakes, then halted = 1 and imem_addr is stable. Deassert halt -> stream resumes at the next sequential PC.
- Async reset mid-stream at PC 0x30 -> outputs 0 immediately; after release, instr_pc = 0x0 and fetch_count = 0.
